e603_subsys_icb2axi: RTL and testbench
======================================

# e603_subsys_icb2axi

Single-outstanding bridge from an ICB command/response target port to an AXI4 single-beat master port. It is the initiator counterpart of the subsystem's AXI-to-ICB/SRAM path: it lets an ICB agent (debug, DMA or test master) issue reads and writes onto the subsystem AXI fabric. Every ICB command becomes exactly one AXI transaction with len=0, and exactly one ICB response is returned.

## Interface
Parameters:
- AW, 32, address width (ICB and AXI).
- DW, 32, data width; MW = DW/8 is derived and is not a parameter.
- ID_W, 4, AXI ID width.
- AXI_ID, 0, constant ID driven on AR/AW and expected on R/B.

Ports. Clock and reset:
- clk  in  1  single clock; everything is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.

ICB side:
- icb_cmd_valid/icb_cmd_ready  in/out  1  command handshake.
- icb_cmd_read  in  1  1=read, 0=write.
- icb_cmd_addr  in  AW  byte address, passed through unaligned.
- icb_cmd_size  in  3  log2 bytes; driven to axi_arsize/axi_awsize.
- icb_cmd_wdata/icb_cmd_wmask  in  DW/MW  write data and byte mask.
- icb_rsp_valid/icb_rsp_ready  out/in  1  response handshake.
- icb_rsp_rdata  out  DW  read data; 0 for writes.
- icb_rsp_err  out  1  error flag.

AXI side:
- axi_arvalid/axi_arready  out/in  1  read address handshake.
- axi_arid, axi_araddr, axi_arsize  out  ID_W/AW/3  = AXI_ID, latched addr, latched size.
- axi_arlen, axi_arburst  out  8/2  constant 0 and INCR (2'b01).
- axi_awvalid/axi_awready  out/in  1  write address handshake.
- axi_awid, axi_awaddr, axi_awsize, axi_awlen, axi_awburst  out  as for AR.
- axi_wvalid/axi_wready  out/in  1  write data handshake.
- axi_wdata, axi_wstrb, axi_wlast  out  DW/MW/1  latched wdata, latched wmask, constant 1.
- axi_rvalid/axi_rready  in/out  1  read data handshake.
- axi_rid, axi_rdata, axi_rresp, axi_rlast  in  ID_W/DW/2/1  read beat.
- axi_bvalid/axi_bready  in/out  1  write response handshake.
- axi_bid, axi_bresp  in  ID_W/2  write response.

## Operation
- FSM states are IDLE, RD_A, RD_D, WR_A, WR_B, RSP. Reset state is IDLE.
- IDLE: icb_cmd_ready=1. On cmd handshake, latch addr, size, wdata, wmask and read. Go to RD_A if read, otherwise WR_A.
- RD_A: axi_arvalid=1 and the AR fields stay stable. On arready, go to RD_D.
- RD_D: axi_rready=1. On rvalid, latch rdata. err = rresp[1] | ~rlast | (rid != AXI_ID). Go to RSP.
- WR_A: axi_awvalid and axi_wvalid both rise on entry. Each one drops independently after its own handshake, tracked by the aw_done and w_done flags. Go to WR_B when both are done, including when both handshake in the same cycle.
- WR_B: axi_bready=1. On bvalid, err = bresp[1] | (bid != AXI_ID). rdata is cleared to 0. Go to RSP.
- RSP: icb_rsp_valid=1 with rdata and err held stable. On rsp_ready, go to IDLE and clear aw_done and w_done.
- OKAY and EXOKAY count as success; SLVERR and DECERR set err.
- Only one transaction is ever outstanding. icb_cmd_ready=0 in every state except IDLE.

## Timing
- All AXI and ICB outputs are driven from registers or decoded from state only. There is no combinational path from any input to any output.
- Reset values: icb_cmd_ready=1 (IDLE). Every valid and ready output, icb_rsp_err, icb_rsp_rdata and all latched fields are 0.
- Minimum read latency, with cmd accepted at cycle T: arvalid at T+1, rready at T+2; if arready and rvalid are both immediate, rsp_valid at T+3.
- Minimum write latency is the same: aw/wvalid at T+1, bready at T+2, rsp_valid at T+3.
- Back-to-back commands: the next cmd_ready is at the cycle after the rsp handshake. Minimum period is 4 cycles.
- Valid signals never drop before their handshake, and their payload is stable while valid.
- Reset asserted mid-transaction: all outputs return asynchronously to reset values and the transaction is abandoned. The downstream AXI slave must be reset in the same domain.

## Structure
- Shared package/defines hold the FSM state encodings, AXI_BURST_INCR, and the AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants.
- No sub-module is needed. State and payload registers use the existing general DFF cells with load enable.

## Test plan
- Read: cmd addr=0x1000_0008, size=2, with arready/rvalid immediate and rdata=0xDEADBEEF, rresp=0 -> araddr=0x1000_0008, arlen=0, rsp_valid at T+3, rdata=0xDEADBEEF, err=0.
- Write with skew: wready arrives 3 cycles before awready -> wvalid drops after its handshake, awvalid is held; bready follows the later handshake. bresp=2 -> err=1, rdata=0.
- Simultaneous AW and W handshake in the first cycle -> both valids drop together and the FSM reaches WR_B next cycle.
- Read with rresp=0, rid=AXI_ID+1 -> err=1. Read with rlast=0 -> err=1.
- Backpressure: rsp_ready held low for 5 cycles -> rsp payload is stable and cmd_ready stays 0; a new cmd is accepted the cycle after the rsp handshake.
- rst_n pulsed while in RD_A -> arvalid=0 immediately, state is IDLE, cmd_ready=1 after release.

Source files
------------

// File: rtl/e603_subsys_icb2axi_pkg.sv
// Shared encodings for the ICB-to-AXI single-outstanding bridge: FSM states,
// AXI burst/response constants and the response error decode.
package e603_subsys_icb2axi_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_D = 3'd2,
        WR_A = 3'd3,
        WR_B = 3'd4,
        RSP  = 3'd5
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // OKAY and EXOKAY are both success; only the slave/decode errors flag.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
    endfunction

endpackage

// File: rtl/e603_subsys_icb2axi_if.sv
// ICB command/response port and AXI4 single-beat port used by the bridge.
// The bridge is the ICB slave and the AXI master.
interface e603_subsys_icb2axi_icb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    localparam int MW = DW / 8;

    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_read;
    logic [AW-1:0] cmd_addr;
    logic [2:0]    cmd_size;
    logic [DW-1:0] cmd_wdata;
    logic [MW-1:0] cmd_wmask;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    modport master (
        output cmd_valid, cmd_read, cmd_addr, cmd_size, cmd_wdata, cmd_wmask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_read, cmd_addr, cmd_size, cmd_wdata, cmd_wmask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

interface e603_subsys_icb2axi_axi_if #(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int ID_W = 4
);
    localparam int MW = DW / 8;

    logic            arvalid;
    logic            arready;
    logic [ID_W-1:0] arid;
    logic [AW-1:0]   araddr;
    logic [2:0]      arsize;
    logic [7:0]      arlen;
    logic [1:0]      arburst;
    logic            awvalid;
    logic            awready;
    logic [ID_W-1:0] awid;
    logic [AW-1:0]   awaddr;
    logic [2:0]      awsize;
    logic [7:0]      awlen;
    logic [1:0]      awburst;
    logic            wvalid;
    logic            wready;
    logic [DW-1:0]   wdata;
    logic [MW-1:0]   wstrb;
    logic            wlast;
    logic            rvalid;
    logic            rready;
    logic [ID_W-1:0] rid;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            bvalid;
    logic            bready;
    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;

    modport master (
        output arvalid, arid, araddr, arsize, arlen, arburst,
        output awvalid, awid, awaddr, awsize, awlen, awburst,
        output wvalid, wdata, wstrb, wlast, rready, bready,
        input  arready, awready, wready,
        input  rvalid, rid, rdata, rresp, rlast,
        input  bvalid, bid, bresp
    );

    modport slave (
        input  arvalid, arid, araddr, arsize, arlen, arburst,
        input  awvalid, awid, awaddr, awsize, awlen, awburst,
        input  wvalid, wdata, wstrb, wlast, rready, bready,
        output arready, awready, wready,
        output rvalid, rid, rdata, rresp, rlast,
        output bvalid, bid, bresp
    );
endinterface

// File: rtl/e603_subsys_icb2axi.sv
// Single-outstanding ICB-to-AXI4 bridge: each ICB command becomes one len=0
// AXI transaction and returns exactly one ICB response.
module e603_subsys_icb2axi
    import e603_subsys_icb2axi_pkg::*;
#(
    parameter int              AW     = 32,
    parameter int              DW     = 32,
    parameter int              ID_W   = 4,
    parameter logic [ID_W-1:0] AXI_ID = '0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    e603_subsys_icb2axi_icb_if.slave          icb,
    e603_subsys_icb2axi_axi_if.master         axi
);

    localparam int MW = DW / 8;

    state_t        state_q, state_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic [AW-1:0] addr_q;
    logic [2:0]    size_q;
    logic [DW-1:0] wdata_q;
    logic [MW-1:0] wmask_q;
    logic [DW-1:0] rdata_q;
    logic          err_q;

    logic cmd_fire, r_fire, b_fire;

    assign cmd_fire = (state_q == IDLE) && icb.cmd_valid;
    assign r_fire   = (state_q == RD_D) && axi.rvalid;
    assign b_fire   = (state_q == WR_B) && axi.bvalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: begin
                if (icb.cmd_valid) state_d = icb.cmd_read ? RD_A : WR_A;
            end
            RD_A: begin
                if (axi.arready) state_d = RD_D;
            end
            RD_D: begin
                if (axi.rvalid) state_d = RSP;
            end
            WR_A: begin
                // AW and W complete independently; either order or the same cycle.
                aw_done_d = aw_done_q | axi.awready;
                w_done_d  = w_done_q  | axi.wready;
                if (aw_done_d && w_done_d) state_d = WR_B;
            end
            WR_B: begin
                if (axi.bvalid) state_d = RSP;
            end
            RSP: begin
                if (icb.rsp_ready) begin
                    state_d   = IDLE;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else if (cmd_fire) begin
            addr_q  <= icb.cmd_addr;
            size_q  <= icb.cmd_size;
            wdata_q <= icb.cmd_wdata;
            wmask_q <= icb.cmd_wmask;
        end
    end

    // Response payload is captured once and held through the whole RSP phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (r_fire) begin
            rdata_q <= axi.rdata;
            err_q   <= resp_is_err(axi.rresp) | ~axi.rlast | (axi.rid != AXI_ID);
        end else if (b_fire) begin
            rdata_q <= '0;
            err_q   <= resp_is_err(axi.bresp) | (axi.bid != AXI_ID);
        end
    end

    assign icb.cmd_ready = (state_q == IDLE);
    assign icb.rsp_valid = (state_q == RSP);
    assign icb.rsp_rdata = rdata_q;
    assign icb.rsp_err   = err_q;

    assign axi.arvalid = (state_q == RD_A);
    assign axi.arid    = AXI_ID;
    assign axi.araddr  = addr_q;
    assign axi.arsize  = size_q;
    assign axi.arlen   = 8'd0;
    assign axi.arburst = AXI_BURST_INCR;

    assign axi.awvalid = (state_q == WR_A) && !aw_done_q;
    assign axi.awid    = AXI_ID;
    assign axi.awaddr  = addr_q;
    assign axi.awsize  = size_q;
    assign axi.awlen   = 8'd0;
    assign axi.awburst = AXI_BURST_INCR;

    assign axi.wvalid  = (state_q == WR_A) && !w_done_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wmask_q;
    assign axi.wlast   = 1'b1;

    assign axi.rready  = (state_q == RD_D);
    assign axi.bready  = (state_q == WR_B);

endmodule

// File: tb/tb_e603_subsys_icb2axi.sv
// Directed bench for the ICB-to-AXI bridge: a vector table of single
// transactions with immediate AXI handshakes, plus multi-cycle corner sequences.
module tb_e603_subsys_icb2axi;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    e603_subsys_icb2axi_icb_if #(.AW(32), .DW(32)) icb_if ();
    e603_subsys_icb2axi_axi_if #(.AW(32), .DW(32), .ID_W(4)) axi_if ();

    e603_subsys_icb2axi #(.AW(32), .DW(32), .ID_W(4), .AXI_ID(4'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .icb   (icb_if),
        .axi   (axi_if)
    );

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        icb_if.cmd_valid = 1'b0;
        icb_if.cmd_read  = 1'b0;
        icb_if.cmd_addr  = '0;
        icb_if.cmd_size  = '0;
        icb_if.cmd_wdata = '0;
        icb_if.cmd_wmask = '0;
        icb_if.rsp_ready = 1'b0;
        axi_if.arready   = 1'b0;
        axi_if.awready   = 1'b0;
        axi_if.wready    = 1'b0;
        axi_if.rvalid    = 1'b0;
        axi_if.rid       = '0;
        axi_if.rdata     = '0;
        axi_if.rresp     = '0;
        axi_if.rlast     = 1'b0;
        axi_if.bvalid    = 1'b0;
        axi_if.bid       = '0;
        axi_if.bresp     = '0;
    endtask

    task automatic drive_cmd(input logic rd, input logic [31:0] addr, input logic [2:0] size,
                             input logic [31:0] wdata, input logic [3:0] wmask);
        icb_if.cmd_valid = 1'b1;
        icb_if.cmd_read  = rd;
        icb_if.cmd_addr  = addr;
        icb_if.cmd_size  = size;
        icb_if.cmd_wdata = wdata;
        icb_if.cmd_wmask = wmask;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h1000_0008, 3'd2, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'd0, 1'b1, 4'd0, 32'hDEAD_BEEF, 1'b0};
        vecs[1]  = '{1'b1, 32'h1000_0011, 3'd0, 32'h0, 4'h0, 32'h1234_5678, 2'd1, 1'b1, 4'd0, 32'h1234_5678, 1'b0};
        vecs[2]  = '{1'b1, 32'h2000_0002, 3'd1, 32'h0, 4'h0, 32'hA5A5_A5A5, 2'd2, 1'b1, 4'd0, 32'hA5A5_A5A5, 1'b1};
        vecs[3]  = '{1'b1, 32'h2000_0100, 3'd2, 32'h0, 4'h0, 32'h0F0F_0F0F, 2'd3, 1'b1, 4'd0, 32'h0F0F_0F0F, 1'b1};
        vecs[4]  = '{1'b1, 32'h3000_0004, 3'd2, 32'h0, 4'h0, 32'h0000_0001, 2'd0, 1'b1, 4'd1, 32'h0000_0001, 1'b1};
        vecs[5]  = '{1'b1, 32'h3000_0008, 3'd2, 32'h0, 4'h0, 32'h8000_0000, 2'd0, 1'b0, 4'd0, 32'h8000_0000, 1'b1};
        vecs[6]  = '{1'b0, 32'h4000_0000, 3'd2, 32'hCAFE_0001, 4'hF, 32'h0, 2'd0, 1'b1, 4'd0, 32'h0, 1'b0};
        vecs[7]  = '{1'b0, 32'h4000_0003, 3'd0, 32'h0000_0099, 4'h8, 32'h0, 2'd1, 1'b1, 4'd0, 32'h0, 1'b0};
        vecs[8]  = '{1'b0, 32'h4000_0010, 3'd1, 32'h7777_8888, 4'h3, 32'h0, 2'd3, 1'b1, 4'd0, 32'h0, 1'b1};
        vecs[9]  = '{1'b0, 32'h4000_0020, 3'd2, 32'h1111_2222, 4'hC, 32'h0, 2'd0, 1'b1, 4'd2, 32'h0, 1'b1};
        vecs[10] = '{1'b1, 32'h5000_0040, 3'd2, 32'h0, 4'h0, 32'h6666_9999, 2'd0, 1'b1, 4'd0, 32'h6666_9999, 1'b0};

        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        chk("rst_cmd_ready", 32'(icb_if.cmd_ready), 32'd1);
        chk("rst_arvalid",   32'(axi_if.arvalid),   32'd0);
        chk("rst_awvalid",   32'(axi_if.awvalid),   32'd0);
        chk("rst_wvalid",    32'(axi_if.wvalid),    32'd0);
        chk("rst_rready",    32'(axi_if.rready),    32'd0);
        chk("rst_bready",    32'(axi_if.bready),    32'd0);
        chk("rst_rsp_valid", 32'(icb_if.rsp_valid), 32'd0);
        chk("rst_rsp_err",   32'(icb_if.rsp_err),   32'd0);
        chk("rst_rsp_rdata", icb_if.rsp_rdata,      32'd0);
        chk("rst_araddr",    axi_if.araddr,         32'd0);
        #3 rst_n = 1'b1;
        step();

        // Table: one transaction per vector, every AXI handshake immediate.
        for (int i = 0; i < 11; i++) begin
            chk("v_idle_ready", 32'(icb_if.cmd_ready), 32'd1);
            drive_cmd(vecs[i].rd, vecs[i].addr, vecs[i].size, vecs[i].wdata, vecs[i].wmask);
            icb_if.rsp_ready = 1'b1;
            axi_if.arready = 1'b1;
            axi_if.awready = 1'b1;
            axi_if.wready  = 1'b1;
            axi_if.rvalid  = vecs[i].rd;
            axi_if.rdata   = vecs[i].rdata;
            axi_if.rresp   = vecs[i].resp;
            axi_if.rlast   = vecs[i].last;
            axi_if.rid     = vecs[i].id;
            axi_if.bvalid  = !vecs[i].rd;
            axi_if.bresp   = vecs[i].resp;
            axi_if.bid     = vecs[i].id;
            step();
            icb_if.cmd_valid = 1'b0;
            chk("v_busy_ready", 32'(icb_if.cmd_ready), 32'd0);
            if (vecs[i].rd) begin
                chk("v_arvalid", 32'(axi_if.arvalid), 32'd1);
                chk("v_awvalid", 32'(axi_if.awvalid), 32'd0);
                chk("v_araddr",  axi_if.araddr,       vecs[i].addr);
                chk("v_arsize",  32'(axi_if.arsize),  32'(vecs[i].size));
                chk("v_arlen",   32'(axi_if.arlen),   32'd0);
                chk("v_arburst", 32'(axi_if.arburst), 32'd1);
                chk("v_arid",    32'(axi_if.arid),    32'd0);
            end else begin
                chk("v_awvalid", 32'(axi_if.awvalid), 32'd1);
                chk("v_wvalid",  32'(axi_if.wvalid),  32'd1);
                chk("v_arvalid", 32'(axi_if.arvalid), 32'd0);
                chk("v_awaddr",  axi_if.awaddr,       vecs[i].addr);
                chk("v_awsize",  32'(axi_if.awsize),  32'(vecs[i].size));
                chk("v_awlen",   32'(axi_if.awlen),   32'd0);
                chk("v_awburst", 32'(axi_if.awburst), 32'd1);
                chk("v_wdata",   axi_if.wdata,        vecs[i].wdata);
                chk("v_wstrb",   32'(axi_if.wstrb),   32'(vecs[i].wmask));
                chk("v_wlast",   32'(axi_if.wlast),   32'd1);
            end
            step();
            if (vecs[i].rd) begin
                chk("v_rready",   32'(axi_if.rready),  32'd1);
                chk("v_arvalid2", 32'(axi_if.arvalid), 32'd0);
            end else begin
                chk("v_bready",   32'(axi_if.bready),  32'd1);
                chk("v_awvalid2", 32'(axi_if.awvalid), 32'd0);
                chk("v_wvalid2",  32'(axi_if.wvalid),  32'd0);
            end
            step();
            chk("v_rsp_valid", 32'(icb_if.rsp_valid), 32'd1);
            chk("v_rsp_rdata", icb_if.rsp_rdata,      vecs[i].exp_rdata);
            chk("v_rsp_err",   32'(icb_if.rsp_err),   32'(vecs[i].exp_err));
            chk("v_rready3",   32'(axi_if.rready),    32'd0);
            chk("v_bready3",   32'(axi_if.bready),    32'd0);
            step();
            chk("v_rsp_done",  32'(icb_if.rsp_valid), 32'd0);
            idle_inputs();
        end

        // Write skew: W handshakes three cycles before AW; bresp=SLVERR.
        drive_cmd(1'b0, 32'h4000_0004, 3'd2, 32'h55AA_55AA, 4'h3);
        icb_if.rsp_ready = 1'b1;
        step();
        icb_if.cmd_valid = 1'b0;
        chk("sk_awvalid0", 32'(axi_if.awvalid), 32'd1);
        chk("sk_wvalid0",  32'(axi_if.wvalid),  32'd1);
        axi_if.wready = 1'b1;
        step();
        axi_if.wready = 1'b0;
        chk("sk_wvalid1",  32'(axi_if.wvalid),  32'd0);
        chk("sk_awvalid1", 32'(axi_if.awvalid), 32'd1);
        chk("sk_bready1",  32'(axi_if.bready),  32'd0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("sk_awhold",   32'(axi_if.awvalid), 32'd1);
            chk("sk_awaddr",   axi_if.awaddr,       32'h4000_0004);
            chk("sk_wlow",     32'(axi_if.wvalid),  32'd0);
            chk("sk_bready_w", 32'(axi_if.bready),  32'd0);
        end
        axi_if.awready = 1'b1;
        step();
        axi_if.awready = 1'b0;
        chk("sk_awvalid2", 32'(axi_if.awvalid), 32'd0);
        chk("sk_bready2",  32'(axi_if.bready),  32'd1);
        axi_if.bvalid = 1'b1;
        axi_if.bresp  = 2'd2;
        step();
        axi_if.bvalid = 1'b0;
        chk("sk_rsp_valid", 32'(icb_if.rsp_valid), 32'd1);
        chk("sk_rsp_err",   32'(icb_if.rsp_err),   32'd1);
        chk("sk_rsp_rdata", icb_if.rsp_rdata,      32'd0);
        step();
        chk("sk_idle", 32'(icb_if.cmd_ready), 32'd1);
        idle_inputs();

        // Response backpressure with a second command waiting.
        drive_cmd(1'b1, 32'h2000_0010, 3'd2, 32'h0, 4'h0);
        axi_if.arready = 1'b1;
        axi_if.rvalid  = 1'b1;
        axi_if.rdata   = 32'hCAFE_F00D;
        axi_if.rlast   = 1'b1;
        step();
        icb_if.cmd_valid = 1'b0;
        step();
        step();
        drive_cmd(1'b0, 32'h3000_0000, 3'd2, 32'h1122_3344, 4'hF);
        axi_if.awready = 1'b1;
        axi_if.wready  = 1'b1;
        axi_if.bvalid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_valid", 32'(icb_if.rsp_valid), 32'd1);
            chk("bp_rsp_rdata", icb_if.rsp_rdata,      32'hCAFE_F00D);
            chk("bp_rsp_err",   32'(icb_if.rsp_err),   32'd0);
            chk("bp_cmd_ready", 32'(icb_if.cmd_ready), 32'd0);
            if (k < 4) step();
        end
        icb_if.rsp_ready = 1'b1;
        step();
        chk("bp_ready_after", 32'(icb_if.cmd_ready), 32'd1);
        chk("bp_rsp_gone",    32'(icb_if.rsp_valid), 32'd0);
        step();
        icb_if.cmd_valid = 1'b0;
        chk("bp_next_awvalid", 32'(axi_if.awvalid), 32'd1);
        chk("bp_next_awaddr",  axi_if.awaddr,       32'h3000_0000);
        chk("bp_next_busy",    32'(icb_if.cmd_ready), 32'd0);
        step();
        chk("bp_next_bready", 32'(axi_if.bready), 32'd1);
        step();
        chk("bp_next_rsp",   32'(icb_if.rsp_valid), 32'd1);
        chk("bp_next_rdata", icb_if.rsp_rdata,      32'd0);
        step();
        idle_inputs();

        // Asynchronous reset while the read address is pending.
        drive_cmd(1'b1, 32'h5000_0000, 3'd2, 32'h0, 4'h0);
        step();
        icb_if.cmd_valid = 1'b0;
        chk("rr_arvalid_pre", 32'(axi_if.arvalid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rr_arvalid_rst", 32'(axi_if.arvalid),   32'd0);
        chk("rr_ready_rst",   32'(icb_if.cmd_ready), 32'd1);
        chk("rr_araddr_rst",  axi_if.araddr,         32'd0);
        #2 rst_n = 1'b1;
        step();
        chk("rr_ready_after",   32'(icb_if.cmd_ready), 32'd1);
        chk("rr_arvalid_after", 32'(axi_if.arvalid),   32'd0);
        chk("rr_rsp_after",     32'(icb_if.rsp_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
